// File: rtl/tg_pkg.sv
// Shared types and constants for the multi-channel timing generator.
// Config register map, channel state encoding and config bundles.
package tg_pkg;

    localparam int CFG_W = 16;

    localparam logic [2:0] CFG_LINE_LEN  = 3'd0;
    localparam logic [2:0] CFG_FRAME_LEN = 3'd1;
    localparam logic [2:0] CFG_HSYNC_W   = 3'd2;
    localparam logic [2:0] CFG_VSYNC_W   = 3'd3;
    localparam logic [2:0] CFG_OFFSET    = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        RUN
    } tg_state_t;

    typedef struct packed {
        logic [CFG_W-1:0] line_len;
        logic [CFG_W-1:0] frame_len;
        logic [CFG_W-1:0] hsync_w;
        logic [CFG_W-1:0] vsync_w;
        logic [CFG_W-1:0] offset;
    } tg_cfg_t;

    typedef struct packed {
        logic [CFG_W-1:0] line_len;
        logic [CFG_W-1:0] frame_len;
        logic [CFG_W-1:0] hsync_w;
        logic [CFG_W-1:0] vsync_w;
    } tg_geom_t;

    // Frame geometry as used by a running channel, with length clamps.
    function automatic tg_geom_t tg_load(input tg_cfg_t c);
        tg_geom_t g;
        g.line_len  = (c.line_len < CFG_W'(2)) ? CFG_W'(2) : c.line_len;
        g.frame_len = (c.frame_len == '0) ? CFG_W'(1) : c.frame_len;
        g.hsync_w   = c.hsync_w;
        g.vsync_w   = c.vsync_w;
        return g;
    endfunction

endpackage

// File: rtl/tg_channel.sv
// One timing channel: start FSM, pixel/line counters,
// shadow and active geometry, registered sync decode.
module tg_channel
    import tg_pkg::*;
#(
    parameter int PIX_W         = 12,
    parameter int LINE_W        = 12,
    parameter int DEF_LINE_LEN  = 1650,
    parameter int DEF_FRAME_LEN = 750,
    parameter int DEF_HSYNC_W   = 40,
    parameter int DEF_VSYNC_W   = 5
) (
    input  logic        clk_gen,
    input  logic        reset,
    input  logic        enable,
    input  logic        mode_single,
    input  logic        trig,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic        sync_line,
    output logic        sync_frame,
    output logic        active,
    output logic        frame_start,
    output logic        busy
);

    localparam logic [CFG_W-1:0] PIX_MASK  = CFG_W'((32'd1 << PIX_W) - 32'd1);
    localparam logic [CFG_W-1:0] LINE_MASK = CFG_W'((32'd1 << LINE_W) - 32'd1);

    localparam tg_cfg_t CFG_DEF = '{
        line_len:  CFG_W'(DEF_LINE_LEN) & PIX_MASK,
        frame_len: CFG_W'(DEF_FRAME_LEN) & LINE_MASK,
        hsync_w:   CFG_W'(DEF_HSYNC_W) & PIX_MASK,
        vsync_w:   CFG_W'(DEF_VSYNC_W) & LINE_MASK,
        offset:    '0
    };
    localparam tg_geom_t GEO_DEF = tg_load(CFG_DEF);

    tg_state_t         state, state_n;
    logic [PIX_W-1:0]  pix, pix_n;
    logic [LINE_W-1:0] line, line_n;
    logic [CFG_W-1:0]  dcnt, dcnt_n;
    tg_cfg_t           shd, shd_n;
    tg_geom_t          geo, geo_n;
    logic              load;
    logic              start;
    logic              last_pix;
    logic              last_line;
    logic              run_n;
    logic [CFG_W-1:0]  pix_x;
    logic [CFG_W-1:0]  line_x;

    assign start     = enable && (!mode_single || trig);
    assign last_pix  = CFG_W'(pix) == geo.line_len - CFG_W'(1);
    assign last_line = CFG_W'(line) == geo.frame_len - CFG_W'(1);

    // Writes land in the shadow combinationally so a boundary load sees them.
    always_comb begin
        shd_n = shd;
        if (wr_en) begin
            case (wr_addr)
                CFG_LINE_LEN:  shd_n.line_len  = wr_data & PIX_MASK;
                CFG_FRAME_LEN: shd_n.frame_len = wr_data & LINE_MASK;
                CFG_HSYNC_W:   shd_n.hsync_w   = wr_data & PIX_MASK;
                CFG_VSYNC_W:   shd_n.vsync_w   = wr_data & LINE_MASK;
                CFG_OFFSET:    shd_n.offset    = wr_data & PIX_MASK;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        pix_n   = pix;
        line_n  = line;
        dcnt_n  = dcnt;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (shd_n.offset == '0) begin
                        state_n = RUN;
                        load    = 1'b1;
                    end else begin
                        state_n = DELAY;
                        dcnt_n  = shd_n.offset - CFG_W'(1);
                    end
                end
            end
            DELAY: begin
                if (dcnt == '0) begin
                    state_n = RUN;
                    load    = 1'b1;
                end else begin
                    dcnt_n = dcnt - CFG_W'(1);
                end
            end
            RUN: begin
                if (last_pix) begin
                    pix_n = '0;
                    if (last_line) begin
                        line_n = '0;
                        if (!mode_single && enable) begin
                            load = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        line_n = line + LINE_W'(1);
                    end
                end else begin
                    pix_n = pix + PIX_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        geo_n = load ? tg_load(shd_n) : geo;
    end

    assign run_n  = state_n == RUN;
    assign pix_x  = CFG_W'(pix_n);
    assign line_x = CFG_W'(line_n);

    always_ff @(posedge clk_gen or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pix         <= '0;
            line        <= '0;
            dcnt        <= '0;
            shd         <= CFG_DEF;
            geo         <= GEO_DEF;
            sync_line   <= 1'b0;
            sync_frame  <= 1'b0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            pix         <= pix_n;
            line        <= line_n;
            dcnt        <= dcnt_n;
            shd         <= shd_n;
            geo         <= geo_n;
            sync_line   <= run_n && (pix_x < geo_n.hsync_w);
            sync_frame  <= run_n && (line_x < geo_n.vsync_w);
            active      <= run_n && (pix_x >= geo_n.hsync_w)
                                 && (line_x >= geo_n.vsync_w);
            frame_start <= run_n && (pix_n == '0) && (line_n == '0);
            busy        <= state_n != IDLE;
        end
    end

endmodule

// File: rtl/timing_generator_multi.sv
// Multi-channel timing generator top: config write decode
// and NUM_CH independent tg_channel instances.
module timing_generator_multi
    import tg_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int PIX_W         = 12,
    parameter int LINE_W        = 12,
    parameter int DEF_LINE_LEN  = 1650,
    parameter int DEF_FRAME_LEN = 750,
    parameter int DEF_HSYNC_W   = 40,
    parameter int DEF_VSYNC_W   = 5
) (
    input  logic              clk_gen,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] mode_single,
    input  logic [NUM_CH-1:0] trig,
    input  logic              cfg_wr,
    input  logic [2:0]        cfg_ch,
    input  logic [2:0]        cfg_addr,
    input  logic [15:0]       cfg_data,
    output logic [NUM_CH-1:0] sync_line,
    output logic [NUM_CH-1:0] sync_frame,
    output logic [NUM_CH-1:0] active,
    output logic [NUM_CH-1:0] frame_start,
    output logic [NUM_CH-1:0] busy
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_en;
        assign wr_en = cfg_wr && (cfg_ch == 3'(i));

        tg_channel #(
            .PIX_W        (PIX_W),
            .LINE_W       (LINE_W),
            .DEF_LINE_LEN (DEF_LINE_LEN),
            .DEF_FRAME_LEN(DEF_FRAME_LEN),
            .DEF_HSYNC_W  (DEF_HSYNC_W),
            .DEF_VSYNC_W  (DEF_VSYNC_W)
        ) u_ch (
            .clk_gen    (clk_gen),
            .reset      (reset),
            .enable     (enable[i]),
            .mode_single(mode_single[i]),
            .trig       (trig[i]),
            .wr_en      (wr_en),
            .wr_addr    (cfg_addr),
            .wr_data    (cfg_data),
            .sync_line  (sync_line[i]),
            .sync_frame (sync_frame[i]),
            .active     (active[i]),
            .frame_start(frame_start[i]),
            .busy       (busy[i])
        );
    end

endmodule

// File: tb/tb_timing_generator_multi.sv
// Directed bench for timing_generator_multi with
// hand-computed counts of sync/active/frame_start cycles.
module tb_timing_generator_multi;

    localparam int NUM_CH = 2;

    logic              clk_gen = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] enable = '0;
    logic [NUM_CH-1:0] mode_single = '0;
    logic [NUM_CH-1:0] trig = '0;
    logic              cfg_wr = 1'b0;
    logic [2:0]        cfg_ch = '0;
    logic [2:0]        cfg_addr = '0;
    logic [15:0]       cfg_data = '0;
    logic [NUM_CH-1:0] sync_line;
    logic [NUM_CH-1:0] sync_frame;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] frame_start;
    logic [NUM_CH-1:0] busy;

    int n_chk = 0;
    int n_fail = 0;

    timing_generator_multi #(.NUM_CH(NUM_CH)) dut (
        .clk_gen    (clk_gen),
        .reset      (reset),
        .enable     (enable),
        .mode_single(mode_single),
        .trig       (trig),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .sync_line  (sync_line),
        .sync_frame (sync_frame),
        .active     (active),
        .frame_start(frame_start),
        .busy       (busy)
    );

    always #5 clk_gen = ~clk_gen;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input int addr, input int data);
        cfg_wr   = 1'b1;
        cfg_ch   = 3'(ch);
        cfg_addr = 3'(addr);
        cfg_data = 16'(data);
        @(negedge clk_gen);
        cfg_wr = 1'b0;
    endtask

    task automatic do_reset();
        enable      = '0;
        mode_single = '0;
        trig        = '0;
        reset       = 1'b0;
        @(negedge clk_gen);
        reset = 1'b1;
        @(negedge clk_gen);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sl"}, int'(sync_line), 0);
        check({tag, "_sf"}, int'(sync_frame), 0);
        check({tag, "_act"}, int'(active), 0);
        check({tag, "_fs"}, int'(frame_start), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int nsl, nsf, nact, nfs, nb, nfs1, nsl1, nact1;
        int f0, f1;
        int fi [3];

        // reset state
        #2 reset = 1'b0;
        @(negedge clk_gen);
        check_all_zero("rst");
        reset = 1'b1;
        @(negedge clk_gen);
        check("idle_busy", int'(busy), 0);

        // defaults, ch0 continuous
        enable = 2'b01;
        @(negedge clk_gen);
        check("def_first_sl", int'(sync_line[0]), 1);
        check("def_first_sf", int'(sync_frame[0]), 1);
        check("def_first_fs", int'(frame_start[0]), 1);
        check("def_first_busy", int'(busy), 1);
        nsl = 0; nsf = 0; nact = 0; nfs = 0;
        for (int i = 0; i < 9900; i++) begin
            nsl  += int'(sync_line[0]);
            nsf  += int'(sync_frame[0]);
            nact += int'(active[0]);
            nfs  += int'(frame_start[0]);
            @(negedge clk_gen);
        end
        check("def_sl_cnt", nsl, 240);
        check("def_sf_cnt", nsf, 8250);
        check("def_act_cnt", nact, 1610);
        check("def_fs_cnt", nfs, 1);
        #3 reset = 1'b0;
        #1 check_all_zero("async_rst1");
        enable = '0;
        @(negedge clk_gen);
        reset = 1'b1;
        @(negedge clk_gen);

        // ch1 programmed with offset, both enabled together
        cfg_write(1, 0, 10);
        cfg_write(1, 1, 4);
        cfg_write(1, 2, 2);
        cfg_write(1, 3, 1);
        cfg_write(1, 4, 7);
        enable = 2'b11;
        @(negedge clk_gen);
        check("ofs_busy", int'(busy), 3);
        check("ofs_fs0", int'(frame_start), 1);
        f0 = -1; f1 = -1; nact = 0; nsl = 0; nsf = 0;
        for (int i = 0; i < 87; i++) begin
            if (frame_start[1]) begin
                if (f0 < 0) f0 = i;
                else if (f1 < 0) f1 = i;
            end
            if (i >= 7 && i < 47) begin
                nact += int'(active[1]);
                nsl  += int'(sync_line[1]);
                nsf  += int'(sync_frame[1]);
            end
            @(negedge clk_gen);
        end
        check("ofs_fs_first", f0, 7);
        check("ofs_fs_second", f1, 47);
        check("ofs_act_cnt", nact, 24);
        check("ofs_sl_cnt", nsl, 8);
        check("ofs_sf_cnt", nsf, 10);
        do_reset();

        // single-shot on ch0, second trig mid-frame
        cfg_write(0, 0, 10);
        cfg_write(0, 1, 4);
        cfg_write(0, 2, 2);
        cfg_write(0, 3, 1);
        mode_single = 2'b01;
        enable = 2'b01;
        repeat (3) @(negedge clk_gen);
        check("ss_wait_busy", int'(busy), 0);
        trig = 2'b01;
        @(negedge clk_gen);
        trig = '0;
        nb = 0; nfs = 0;
        for (int i = 0; i < 100; i++) begin
            nb  += int'(busy[0]);
            nfs += int'(frame_start[0]);
            if (i == 20) trig = 2'b01;
            if (i == 21) trig = '0;
            @(negedge clk_gen);
        end
        check("ss_busy_cnt", nb, 40);
        check("ss_fs_cnt", nfs, 1);

        // mid-frame line_len change applies at the next frame
        mode_single = '0;
        @(negedge clk_gen);
        nfs = 0;
        fi[0] = -1; fi[1] = -1; fi[2] = -1;
        for (int i = 0; i < 130; i++) begin
            if (frame_start[0]) begin
                if (nfs < 3) fi[nfs] = i;
                nfs++;
            end
            if (i == 25) begin
                cfg_wr = 1'b1; cfg_ch = 3'd0;
                cfg_addr = 3'd0; cfg_data = 16'd20;
            end
            if (i == 26) cfg_wr = 1'b0;
            @(negedge clk_gen);
        end
        check("recfg_fs_cnt", nfs, 3);
        check("recfg_fs1", fi[1], 40);
        check("recfg_fs2", fi[2], 120);
        do_reset();

        // enable drop mid-frame, then async reset mid-frame
        cfg_write(0, 0, 10);
        cfg_write(0, 1, 4);
        cfg_write(0, 2, 2);
        cfg_write(0, 3, 1);
        enable = 2'b01;
        @(negedge clk_gen);
        nb = 0; nfs = 0;
        for (int i = 0; i < 60; i++) begin
            nb  += int'(busy[0]);
            nfs += int'(frame_start[0]);
            if (i == 15) enable = '0;
            @(negedge clk_gen);
        end
        check("drop_busy_cnt", nb, 40);
        check("drop_fs_cnt", nfs, 1);
        enable = 2'b01;
        @(negedge clk_gen);
        repeat (12) @(negedge clk_gen);
        check("pre_rst_active", int'(active[0]), 1);
        #3 reset = 1'b0;
        #1 check_all_zero("async_rst2");
        @(negedge clk_gen);
        reset = 1'b1;
        @(negedge clk_gen);
        check("post_rst_fs", int'(frame_start[0]), 1);
        nsl = 0; nact = 0;
        for (int i = 0; i < 1651; i++) begin
            nsl  += int'(sync_line[0]);
            nact += int'(active[0]);
            @(negedge clk_gen);
        end
        check("post_rst_sl_cnt", nsl, 41);
        check("post_rst_act_cnt", nact, 0);
        do_reset();

        // boundaries: clamp, full-width hsync, out-of-range writes
        cfg_write(0, 0, 0);
        cfg_write(0, 1, 2);
        cfg_write(0, 2, 1);
        cfg_write(0, 3, 0);
        cfg_write(1, 0, 10);
        cfg_write(1, 1, 4);
        cfg_write(1, 2, 10);
        cfg_write(1, 3, 1);
        cfg_write(5, 0, 3);
        cfg_write(1, 5, 3);
        enable = 2'b11;
        @(negedge clk_gen);
        nfs = 0; nsl = 0; nact = 0; nsf = 0;
        nfs1 = 0; nsl1 = 0; nact1 = 0;
        for (int i = 0; i < 80; i++) begin
            nfs   += int'(frame_start[0]);
            nsl   += int'(sync_line[0]);
            nact  += int'(active[0]);
            nsf   += int'(sync_frame[0]);
            nfs1  += int'(frame_start[1]);
            nsl1  += int'(sync_line[1]);
            nact1 += int'(active[1]);
            @(negedge clk_gen);
        end
        check("clamp_fs_cnt", nfs, 20);
        check("clamp_sl_cnt", nsl, 40);
        check("clamp_act_cnt", nact, 40);
        check("clamp_sf_cnt", nsf, 0);
        check("hfull_fs_cnt", nfs1, 2);
        check("hfull_sl_cnt", nsl1, 80);
        check("hfull_act_cnt", nact1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/timing_generator_multi.md
# timing_generator_multi

Multi-channel, runtime-programmable successor to the fixed sensor/interface timing generator. It produces NUM_CH independent sync_line / sync_frame / active timing streams (e.g. ch0 = sensor, ch1 = interface) from one clock. Each channel has its own geometry and a start offset in clocks, programmed over a simple register write port. Geometry is shadowed and applied only at frame boundaries. Each channel runs either continuously or as a triggered single frame.

## Interface
Parameters:
- NUM_CH, 2, number of timing channels (1..8)
- PIX_W, 12, pixel counter width
- LINE_W, 12, line counter width
- DEF_LINE_LEN, 1650, reset value of line length (clocks per line)
- DEF_FRAME_LEN, 750, reset value of frame length (lines per frame)
- DEF_HSYNC_W, 40, reset value of sync_line width (clocks)
- DEF_VSYNC_W, 5, reset value of sync_frame width (lines)

Ports:
- clk_gen  in  1  single clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  NUM_CH  per-channel run request
- mode_single  in  NUM_CH  per channel: 1 = single-shot (trig-started), 0 = continuous
- trig  in  NUM_CH  single-shot start pulse, 1 cycle
- cfg_wr  in  1  register write strobe
- cfg_ch  in  3  target channel (writes to cfg_ch >= NUM_CH are ignored)
- cfg_addr  in  3  0 line_len, 1 frame_len, 2 hsync_w, 3 vsync_w, 4 offset; 5..7 ignored
- cfg_data  in  16  write data, truncated to PIX_W (addr 0, 2, 4) or LINE_W (addr 1, 3)
- sync_line  out  NUM_CH  high while pix < hsync_w
- sync_frame  out  NUM_CH  high while line < vsync_w
- active  out  NUM_CH  high while pix >= hsync_w and line >= vsync_w
- frame_start  out  NUM_CH  1-cycle pulse at pix=0, line=0
- busy  out  NUM_CH  channel not IDLE

## Operation
- Per-channel FSM with states IDLE, DELAY, RUN. Counters pix (0..line_len-1) and line (0..frame_len-1).
- IDLE to DELAY:
  - continuous mode: when enable=1;
  - single-shot mode: when enable=1 and trig=1.
  - If offset=0, the channel goes directly to RUN.
- DELAY: counts offset clocks, then enters RUN at pix=0, line=0.
- RUN: pix increments each clock. At pix=line_len-1, pix wraps to 0 and line increments. At the last pixel of line frame_len-1 (frame end):
  - continuous mode with enable=1: next frame starts with no offset delay;
  - otherwise: go to IDLE.
- enable dropping mid-frame does not truncate the frame; the current frame completes, then the channel goes to IDLE.
- trig in any state other than IDLE is ignored. A trig in continuous mode is ignored.
- Shadow registers: cfg writes update the shadow copy immediately. The active copy is loaded from the shadow on every entry to pix=0, line=0 (including the first frame). Geometry never changes mid-frame. offset is read when leaving IDLE.
- Clamps are applied at load time: line_len < 2 becomes 2; frame_len < 1 becomes 1.
- hsync_w >= line_len gives sync_line high for the whole line and active never high. vsync_w has the same effect on lines.
- Reset (asynchronous, any time, including mid-frame):
  - all FSMs go to IDLE and counters to 0;
  - all outputs go to 0;
  - shadow and active registers take the DEF_* values, and offset takes 0.

## Timing
- All outputs are registered, decoded from the next-state counters, so they align with the counter state they describe.
- Continuous mode, offset=0: enable sampled high at edge k puts pix=0, line=0 after edge k. sync_line, sync_frame, frame_start and busy are high in that cycle.
- Offset=N>0: busy rises after edge k; frame_start follows after edge k+N.
- Frame period is exactly line_len × frame_len clocks; back-to-back frames have no gap.
- Single-shot: busy falls on the edge after the last pixel.
- A cfg write in the same cycle as a frame-boundary load is visible in that load (shadow write-through).
- Channels are fully independent: no phase coupling except through a common enable edge plus offsets.

## Structure
- Package tg_pkg holds:
  - cfg address constants (CFG_LINE_LEN … CFG_OFFSET);
  - the state enum tg_state_t {IDLE, DELAY, RUN};
  - the struct tg_cfg_t {line_len, frame_len, hsync_w, vsync_w, offset}.
- Sub-module tg_channel holds one channel (FSM, counters, shadow/active config, output decode). The top instantiates NUM_CH copies with a generate loop and decodes cfg_ch/cfg_addr into per-channel write enables.

## Test plan
- Reset defaults, ch0 continuous, enable=1, offset=0: sync_line 40 clocks high every 1650 clocks; sync_frame high for 5 lines; frame_start every 1,237,500 clocks.
- Programming, ch1: line_len=10, frame_len=4, hsync_w=2, vsync_w=1, offset=7; enable both channels on the same edge. ch1 frame_start occurs 7 clocks after busy rises, then every 40 clocks; active is high for 8 clocks on lines 1..3.
- Single-shot, ch0, geometry 10×4: trig gives exactly one frame of 40 clocks, then busy=0. A second trig sent mid-frame is ignored (still one frame).
- Mid-frame reconfig: write line_len=20 at line 2. The current frame stays at 10-clock lines; the next frame has 20-clock lines.
- enable drop mid-frame, then reset asserted mid-frame: the frame completes then goes to IDLE. Reset forces all outputs to 0 asynchronously, and after release the DEF_* geometry is restored.
- Boundaries: line_len=0 behaves as 2. hsync_w=10 with line_len=10 keeps sync_line constantly high and active=0. A write to cfg_ch=5 with NUM_CH=2 has no effect.
